// File: rtl/mips_multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller owns the master side: it reads the decode fields and flags, and drives every select.
interface mips_multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       memReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] DataToWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUoperation;
    logic [1:0] PCSrc;
    logic [3:0] state;

    modport master (
        input  opcode,
        input  func,
        input  zero,
        input  memReady,
        output PCWrite,
        output PCWriteCond,
        output IorD,
        output MemRead,
        output MemWrite,
        output IRWrite,
        output RegDst,
        output DataToWrite,
        output RegWrite,
        output ALUSrcA,
        output ALUSrcB,
        output ALUoperation,
        output PCSrc,
        output state
    );

    modport slave (
        output opcode,
        output func,
        output zero,
        output memReady,
        input  PCWrite,
        input  PCWriteCond,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        input  IRWrite,
        input  RegDst,
        input  DataToWrite,
        input  RegWrite,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUoperation,
        input  PCSrc,
        input  state
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS controller: steps each instruction through fetch/decode/execute/memory/writeback
// and decodes every datapath select and write enable from the current state.
module mips_multicycle_controller (
    input  logic                                clk,
    input  logic                                rst,
    mips_multicycle_controller_if.master        bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur;
    state_t nxt;

    // The branch decision is taken in the datapath (PCWriteCond & zero), not here.
    logic unused_zero;
    assign unused_zero = bus.zero;

    function automatic logic [2:0] func_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic func_writes(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // Outputs follow the live memReady so IRWrite/PCWrite land exactly on the completing cycle.
    always_comb begin
        nxt              = FETCH;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.RegDst       = 2'b00;
        bus.DataToWrite  = 2'b00;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.ALUoperation = 3'b000;
        bus.PCSrc        = 2'b00;
        bus.state        = 4'd0;
        if (!rst) begin
            bus.state = cur;
            case (cur)
                FETCH: begin
                    bus.MemRead      = 1'b1;
                    bus.ALUSrcB      = 2'b01;
                    bus.ALUoperation = ALU_ADD;
                    if (bus.memReady) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        nxt         = DECODE;
                    end else begin
                        nxt = FETCH;
                    end
                end
                DECODE: begin
                    bus.ALUSrcB      = 2'b11;
                    bus.ALUoperation = ALU_ADD;
                    case (bus.opcode)
                        OP_LW, OP_SW:     nxt = MEMADR;
                        OP_RTYPE:         nxt = (bus.func == FN_JR) ? JR : REXEC;
                        OP_BEQ:           nxt = BRANCH;
                        OP_ADDI, OP_SLTI: nxt = IEXEC;
                        OP_J:             nxt = JUMP;
                        OP_JAL:           nxt = JAL;
                        default:          nxt = FETCH;
                    endcase
                end
                MEMADR: begin
                    bus.ALUSrcA      = 1'b1;
                    bus.ALUSrcB      = 2'b10;
                    bus.ALUoperation = ALU_ADD;
                    if (bus.opcode == OP_LW)      nxt = MEMRD;
                    else if (bus.opcode == OP_SW) nxt = MEMWR;
                    else                          nxt = FETCH;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    nxt         = bus.memReady ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    bus.RegWrite    = 1'b1;
                    bus.RegDst      = 2'b00;
                    bus.DataToWrite = 2'b01;
                    nxt             = FETCH;
                end
                MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                    nxt          = bus.memReady ? FETCH : MEMWR;
                end
                REXEC: begin
                    bus.ALUSrcA      = 1'b1;
                    bus.ALUSrcB      = 2'b00;
                    bus.ALUoperation = func_alu(bus.func);
                    nxt              = RWB;
                end
                RWB: begin
                    // Unrecognised funct values execute as a nop: no register update.
                    bus.RegWrite    = func_writes(bus.func);
                    bus.RegDst      = 2'b01;
                    bus.DataToWrite = 2'b00;
                    nxt             = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA      = 1'b1;
                    bus.ALUoperation = ALU_SUB;
                    bus.PCWriteCond  = 1'b1;
                    bus.PCSrc        = 2'b01;
                    nxt              = FETCH;
                end
                IEXEC: begin
                    bus.ALUSrcA      = 1'b1;
                    bus.ALUSrcB      = 2'b10;
                    bus.ALUoperation = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                    nxt              = IWB;
                end
                IWB: begin
                    bus.RegWrite    = 1'b1;
                    bus.RegDst      = 2'b00;
                    bus.DataToWrite = 2'b00;
                    nxt             = FETCH;
                end
                JUMP: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = 2'b10;
                    nxt         = FETCH;
                end
                JAL: begin
                    // The link value is the PC already advanced in FETCH, sampled before this edge loads the target.
                    bus.PCWrite     = 1'b1;
                    bus.PCSrc       = 2'b10;
                    bus.RegWrite    = 1'b1;
                    bus.RegDst      = 2'b10;
                    bus.DataToWrite = 2'b10;
                    nxt             = FETCH;
                end
                JR: begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = 2'b11;
                    nxt         = FETCH;
                end
                default: begin
                    nxt = FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Instruction-level bench for the multicycle controller: each instruction expands into its
// expected per-cycle output records, which one negedge process compares against the DUT.
module tb_mips_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_BAD = 6'b000000;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] dtw;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } out_t;

  typedef struct packed {
    logic       r;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
    out_t       e;
  } cyc_t;

  cyc_t plan[$];
  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic idle_rdy = 1'b0;

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      FN_ADD:  return 3'b010;
      FN_SUB:  return 3'b110;
      FN_AND:  return 3'b000;
      FN_OR:   return 3'b001;
      FN_SLT:  return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic out_t sample();
    out_t s;
    s.st    = bus.state;
    s.pcw   = bus.PCWrite;
    s.pcwc  = bus.PCWriteCond;
    s.iord  = bus.IorD;
    s.mr    = bus.MemRead;
    s.mw    = bus.MemWrite;
    s.irw   = bus.IRWrite;
    s.rdst  = bus.RegDst;
    s.dtw   = bus.DataToWrite;
    s.rw    = bus.RegWrite;
    s.srca  = bus.ALUSrcA;
    s.srcb  = bus.ALUSrcB;
    s.aluop = bus.ALUoperation;
    s.pcsrc = bus.PCSrc;
    return s;
  endfunction

  task automatic add_cyc(input logic r, input logic rdy, input logic [5:0] op,
                         input logic [5:0] fn, input out_t e);
    cyc_t c;
    c.r = r; c.rdy = rdy; c.op = op; c.fn = fn; c.e = e;
    plan.push_back(c);
  endtask

  // Expand one instruction into cycles: fs fetch stalls, ms memory stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fs, input int ms,
                       output int n);
    int   start;
    out_t e;
    start    = plan.size();
    idle_rdy = ~idle_rdy;
    for (int i = 0; i <= fs; i++) begin
      e = '0; e.st = 4'd0; e.mr = 1'b1; e.srcb = 2'b01; e.aluop = 3'b010;
      if (i == fs) begin e.irw = 1'b1; e.pcw = 1'b1; end
      add_cyc(1'b0, i == fs, op, fn, e);
    end
    e = '0; e.st = 4'd1; e.srcb = 2'b11; e.aluop = 3'b010;
    add_cyc(1'b0, idle_rdy, op, fn, e);
    case (op)
      OP_LW, OP_SW: begin
        e = '0; e.st = 4'd2; e.srca = 1'b1; e.srcb = 2'b10; e.aluop = 3'b010;
        add_cyc(1'b0, idle_rdy, op, fn, e);
        for (int i = 0; i <= ms; i++) begin
          e = '0; e.iord = 1'b1;
          if (op == OP_LW) begin e.st = 4'd3; e.mr = 1'b1; end
          else begin e.st = 4'd5; e.mw = 1'b1; end
          add_cyc(1'b0, i == ms, op, fn, e);
        end
        if (op == OP_LW) begin
          e = '0; e.st = 4'd4; e.rw = 1'b1; e.dtw = 2'b01;
          add_cyc(1'b0, idle_rdy, op, fn, e);
        end
      end
      OP_R: begin
        if (fn == FN_JR) begin
          e = '0; e.st = 4'd13; e.pcw = 1'b1; e.pcsrc = 2'b11;
          add_cyc(1'b0, idle_rdy, op, fn, e);
        end else begin
          e = '0; e.st = 4'd6; e.srca = 1'b1; e.aluop = alu_of(fn);
          add_cyc(1'b0, idle_rdy, op, fn, e);
          e = '0; e.st = 4'd7; e.rdst = 2'b01;
          e.rw = (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT);
          add_cyc(1'b0, idle_rdy, op, fn, e);
        end
      end
      OP_BEQ: begin
        e = '0; e.st = 4'd8; e.srca = 1'b1; e.aluop = 3'b110; e.pcwc = 1'b1; e.pcsrc = 2'b01;
        add_cyc(1'b0, idle_rdy, op, fn, e);
      end
      OP_ADDI, OP_SLTI: begin
        e = '0; e.st = 4'd9; e.srca = 1'b1; e.srcb = 2'b10;
        e.aluop = (op == OP_SLTI) ? 3'b111 : 3'b010;
        add_cyc(1'b0, idle_rdy, op, fn, e);
        e = '0; e.st = 4'd10; e.rw = 1'b1;
        add_cyc(1'b0, idle_rdy, op, fn, e);
      end
      OP_J: begin
        e = '0; e.st = 4'd11; e.pcw = 1'b1; e.pcsrc = 2'b10;
        add_cyc(1'b0, idle_rdy, op, fn, e);
      end
      OP_JAL: begin
        e = '0; e.st = 4'd12; e.pcw = 1'b1; e.pcsrc = 2'b10; e.rw = 1'b1;
        e.rdst = 2'b10; e.dtw = 2'b10;
        add_cyc(1'b0, idle_rdy, op, fn, e);
      end
      default: ;
    endcase
    n = plan.size() - start;
  endtask

  task automatic pin(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: model gives %0d, required %0d", name, got, want);
    end
  endtask

  task automatic play(input logic zero_val);
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      rst          = c.r;
      bus.memReady = c.rdy;
      bus.opcode   = c.op;
      bus.func     = c.fn;
      bus.zero     = zero_val;
      exp_q.push_back(c.e);
    end
  endtask

  always @(negedge clk) begin : compare
    out_t e;
    out_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL cycle_state%0d: got state=%0d outputs=%h, required state=%0d outputs=%h",
                 e.st, g.st, g, e.st, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run still active at time %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int   n;
    out_t last;
    cyc_t dummy;
    bus.opcode = '0; bus.func = '0; bus.zero = 1'b0; bus.memReady = 1'b0;

    add_cyc(1'b1, 1'b0, 6'd0, 6'd0, '0);
    add_cyc(1'b1, 1'b0, 6'd0, 6'd0, '0);
    play(1'b0);

    build(OP_R, FN_ADD, 0, 0, n); pin("radd_cycles", n, 4);
    last = plan[2].e; pin("radd_aluop", int'(last.aluop), 2);
    play(1'b1);
    build(OP_R, FN_SUB, 2, 0, n); pin("rsub_fetch_stall_cycles", n, 6); play(1'b0);
    build(OP_R, FN_AND, 0, 0, n); play(1'b1);
    build(OP_R, FN_OR,  0, 0, n); play(1'b0);
    build(OP_R, FN_SLT, 0, 0, n); play(1'b1);
    build(OP_R, FN_BAD, 0, 0, n);
    last = plan[3].e; pin("rbad_no_write", int'(last.rw), 0);
    play(1'b0);

    build(OP_LW, 6'd0, 0, 2, n); pin("lw_stall_cycles", n, 7);
    last = plan[6].e; pin("lw_wb_dtw", int'(last.dtw), 1);
    play(1'b0);
    build(OP_SW, 6'd0, 1, 1, n); pin("sw_stall_cycles", n, 6); play(1'b1);

    build(OP_BEQ, 6'd0, 0, 0, n); pin("beq_cycles", n, 3);
    last = plan[2].e;
    pin("beq_pcwc", int'(last.pcwc), 1);
    pin("beq_pcsrc", int'(last.pcsrc), 1);
    pin("beq_aluop", int'(last.aluop), 6);
    pin("beq_pcwrite", int'(last.pcw), 0);
    play(1'b1);
    build(OP_BEQ, 6'd0, 0, 0, n); play(1'b0);

    build(OP_ADDI, 6'd0, 0, 0, n); pin("addi_cycles", n, 4); play(1'b0);
    build(OP_SLTI, 6'd0, 0, 0, n); pin("slti_cycles", n, 4); play(1'b1);
    build(OP_J,    6'd0, 0, 0, n); pin("j_cycles", n, 3); play(1'b0);
    build(OP_JAL,  6'd0, 0, 0, n); pin("jal_cycles", n, 3);
    last = plan[2].e; pin("jal_rdst", int'(last.rdst), 2);
    play(1'b1);
    build(OP_R, FN_JR, 0, 0, n); pin("jr_cycles", n, 3); play(1'b0);
    build(OP_BAD, 6'd0, 0, 0, n); pin("illegal_cycles", n, 2); play(1'b1);
    build(OP_LW, 6'd0, 0, 0, n); pin("lw_cycles", n, 5); play(1'b0);

    // Reset lands in the writeback cycle of an add: that cycle and the next must be silent.
    build(OP_R, FN_ADD, 0, 0, n);
    dummy = plan.pop_back();
    add_cyc(1'b1, 1'b1, OP_R, FN_ADD, '0);
    add_cyc(1'b1, 1'b1, OP_R, FN_ADD, '0);
    play(1'b0);
    build(OP_R, FN_ADD, 1, 0, n); play(1'b1);

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Finite-state controller that sequences the multicycle MIPS datapath. It is the multicycle successor to the single-cycle combinational controller. It decodes opcode/funct from the instruction register and steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux select and write enable, and stalls on a shared instruction/data memory through a ready handshake. It sits beside the multicycle DataPath inside the processor top level.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- func  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31.
- DataToWrite  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- ALUoperation  out  3  000 AND, 001 OR, 010 add, 110 sub, 111 slt.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], imm26, 00}, 11 = A (jr).
- state  out  4  current state encoding, for debug and verification.

## Operation
- Default for every output in every state: 0. Only the listed signals are asserted in each state.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, slti 001010, j 000010, jal 000011.
- Supported funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
- FETCH (0)
  - Always asserted: MemRead; ALUSrcB = 01; ALU add.
  - When memReady: IRWrite, PCWrite, and go to DECODE. Otherwise stay in FETCH.
- DECODE (1)
  - Asserted: ALUSrcB = 11; add. This places the branch target in ALUOut.
  - Next state: lw/sw → MEMADR; R-type → JR if func = 001000, else REXEC; beq → BRANCH; addi/slti → IEXEC; j → JUMP; jal → JAL.
  - Unknown opcode → FETCH. The instruction is treated as a nop.
- MEMADR (2): ALUSrcA = 1; ALUSrcB = 10; add. Go to MEMRD if lw, MEMWR if sw.
- MEMRD (3): MemRead; IorD. Go to MEMWB on memReady, else hold.
- MEMWB (4): RegWrite; RegDst = 00; DataToWrite = 01. Go to FETCH.
- MEMWR (5): MemWrite; IorD. Go to FETCH on memReady, else hold.
- REXEC (6): ALUSrcA = 1; ALUSrcB = 00; ALU op from func.
  - Unknown func: add, and the write in RWB is suppressed.
  - Go to RWB.
- RWB (7): RegWrite; RegDst = 01; DataToWrite = 00. Go to FETCH.
- BRANCH (8): ALUSrcA = 1; sub; PCWriteCond; PCSrc = 01. Go to FETCH.
- IEXEC (9): ALUSrcA = 1; ALUSrcB = 10; add for addi, slt for slti. Go to IWB.
- IWB (10): RegWrite; RegDst = 00; DataToWrite = 00. Go to FETCH.
- JUMP (11): PCWrite; PCSrc = 10. Go to FETCH.
- JAL (12): PCWrite; PCSrc = 10; RegWrite; RegDst = 10; DataToWrite = 10.
  - The register write uses the already-incremented PC (old value), captured in the same edge.
  - Go to FETCH.
- JR (13): PCWrite; PCSrc = 11. Go to FETCH.
- Encodings 14 and 15 are illegal: all outputs 0, next state FETCH.
- Outputs are decoded combinationally from state, opcode, func and memReady. The memReady qualification applies only in FETCH, MEMRD and MEMWR.

## Timing
- rst sampled high at an edge → state = FETCH (0) after that edge.
- While rst is high, all outputs are forced to 0, including MemRead. Reset mid-instruction abandons the instruction with no partial register or memory write after the reset edge.
- First fetch request: the cycle after rst deasserts.
- Cycle counts with memReady held high:
  - beq, j, jal, jr: 3 cycles.
  - R-type, sw, addi, slti: 4 cycles.
  - lw: 5 cycles.
- Each cycle memReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- While stalled, MemRead/MemWrite and IorD stay constant. IRWrite and PCWrite stay 0 until the ready cycle.
- In FETCH, IRWrite and PCWrite are asserted only in the cycle memReady = 1. PC and IR update on that edge only.
- opcode/func are read only in DECODE and later. In FETCH they are don't-care.

## Test plan
- Reset and first fetch:
  - Stimulus: rst = 1 for 2 cycles, then 0.
  - Required: state = 0 and all outputs 0 during reset. MemRead = 1, IorD = 0, ALUSrcB = 01 in the first cycle after release.
- R-type add (000000 / 100000), memReady = 1:
  - State sequence 0, 1, 6, 7, 0.
  - ALUoperation = 010 in state 6.
  - RegWrite = 1, RegDst = 01 in state 7 only.
- lw with memReady low for 2 cycles in MEMRD:
  - State sequence 0, 1, 2, 3, 3, 3, 4, 0.
  - MemRead and IorD = 1 held for all three MEMRD cycles.
  - RegWrite with DataToWrite = 01 in state 4.
- beq taken and not-taken:
  - State sequence 0, 1, 8.
  - PCWriteCond = 1, PCSrc = 01, ALUoperation = 110 in state 8.
  - PCWrite stays 0 in both cases; the zero flag gates the PC load in the datapath.
- Jumps (jal, jr):
  - jal: state 12 asserts PCWrite, PCSrc = 10, RegWrite, RegDst = 10, DataToWrite = 10.
  - jr (func 001000): goes to state 13 with PCSrc = 11 and no RegWrite.
- Illegal opcode 111111, then reset:
  - Illegal opcode: returns 1 → 0 with no write enables asserted.
  - rst asserted in state 7: no RegWrite is seen after the reset edge, and state = 0.
